// File: rtl/sha2_add_pkg.sv
// Shared widths, word types and the lane-split carry helper for the SHA-2 adders.
package sha2_add_pkg;

    localparam int unsigned DATA_W         = 64;
    localparam int unsigned LANE_W         = 32;
    localparam int unsigned LANE_SPLIT_BIT = 32;

    typedef logic [DATA_W-1:0] word64_t;
    typedef logic [LANE_W-1:0] word32_t;

    // Carry vectors shift left by one; the bit entering the upper lane only survives in 64-bit mode.
    function automatic word64_t shift_gate(input word64_t maj, input logic mode64);
        word64_t r;
        r                 = maj << 1;
        r[LANE_SPLIT_BIT] = maj[LANE_SPLIT_BIT-1] & mode64;
        return r;
    endfunction

endpackage

// File: rtl/csa_4to2.sv
// Combinational 4:2 carry-save compressor built from two 3:2 rows, with lane-split carry gating.
module csa_4to2
    import sha2_add_pkg::*;
(
    input  word64_t a,
    input  word64_t b,
    input  word64_t c,
    input  word64_t d,
    input  logic    mode64,
    output word64_t sum,
    output word64_t carry
);

    word64_t s1;
    word64_t m1;
    word64_t c1;
    word64_t m2;

    always_comb begin
        s1    = a ^ b ^ c;
        m1    = (a & b) | (a & c) | (b & c);
        c1    = shift_gate(m1, mode64);
        sum   = s1 ^ c1 ^ d;
        m2    = (s1 & c1) | (s1 & d) | (c1 & d);
        carry = shift_gate(m2, mode64);
    end

endmodule

// File: rtl/add64_4_inputs.sv
// Four-operand registered adder, one 64-bit lane or two 32-bit lanes.
// Define ADD64_4IN_PIPE2_EN to register the carry-save vectors (latency 2 instead of 1).
module add64_4_inputs
    import sha2_add_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] AIN,
    input  logic [DATA_W-1:0] BIN,
    input  logic [DATA_W-1:0] CIN,
    input  logic [DATA_W-1:0] DIN,
    input  logic              mode64,
    output logic [DATA_W-1:0] SUM_OUT
);

    word64_t csa_sum;
    word64_t csa_carry;
    word64_t fin_sum;
    word64_t fin_carry;
    logic    fin_mode;
    word64_t result;
    logic [LANE_W:0] lo_sum;
    word32_t         hi_sum;

    csa_4to2 u_csa (
        .a      (AIN),
        .b      (BIN),
        .c      (CIN),
        .d      (DIN),
        .mode64 (mode64),
        .sum    (csa_sum),
        .carry  (csa_carry)
    );

`ifdef ADD64_4IN_PIPE2_EN
    word64_t sum_q;
    word64_t carry_q;
    logic    mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            sum_q   <= csa_sum;
            carry_q <= csa_carry;
            mode_q  <= mode64;
        end
    end

    // The staged mode travels with its vectors so a mode flip never mixes with older data.
    assign fin_sum   = sum_q;
    assign fin_carry = carry_q;
    assign fin_mode  = mode_q;
`else
    assign fin_sum   = csa_sum;
    assign fin_carry = csa_carry;
    assign fin_mode  = mode64;
`endif

    // Carry-propagate add split at the lane boundary so the cross-lane carry can be gated.
    always_comb begin
        lo_sum = {1'b0, fin_sum[LANE_W-1:0]} + {1'b0, fin_carry[LANE_W-1:0]};
        hi_sum = fin_sum[DATA_W-1:LANE_W] + fin_carry[DATA_W-1:LANE_W]
               + {{(LANE_W-1){1'b0}}, lo_sum[LANE_W] & fin_mode};
        result = {hi_sum, lo_sum[LANE_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SUM_OUT <= '0;
        end else begin
            SUM_OUT <= result;
        end
    end

endmodule

// File: tb/tb_add64_4_inputs.sv
// Scoreboard bench for add64_4_inputs: random and directed vectors checked against a plain-arithmetic model.
module tb_add64_4_inputs;

`ifdef ADD64_4IN_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [63:0] c_in;
    logic [63:0] d_in;
    logic        mode64;
    logic [63:0] sum_out;

    add64_4_inputs #(.DATA_W(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .AIN     (a_in),
        .BIN     (b_in),
        .CIN     (c_in),
        .DIN     (d_in),
        .mode64  (mode64),
        .SUM_OUT (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exp;
        int          due;
        int          id;
    } item_t;

    item_t pend[$];
    item_t infl[$];
    int    cyc    = 0;
    int    tests  = 0;
    int    fails  = 0;
    int    issued = 0;

    function automatic logic [63:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c, input logic [63:0] d,
                                            input logic m);
        logic [31:0] lo;
        logic [31:0] hi;
        if (m) return a + b + c + d;
        lo = a[31:0] + b[31:0] + c[31:0] + d[31:0];
        hi = a[63:32] + b[63:32] + c[63:32] + d[63:32];
        return {hi, lo};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] d, input logic m);
        item_t it;
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        c_in   = c;
        d_in   = d;
        mode64 = m;
        it.exp = ref_sum(a, b, c, d, m);
        it.due = 0;
        it.id  = issued;
        issued++;
        pend.push_back(it);
    endtask

    // Monitor: capture what each edge sampled, then compare when its latency has elapsed.
    always @(posedge clk) begin
        item_t e;
        cyc++;
        if (rst_n && pend.size() > 0) begin
            e     = pend.pop_front();
            e.due = cyc + LAT - 1;
            infl.push_back(e);
        end
        #1;
        if (rst_n && infl.size() > 0 && infl[0].due == cyc) begin
            e = infl.pop_front();
            check($sformatf("result#%0d", e.id), sum_out, e.exp);
        end
    end

    initial begin
        logic [63:0] sa, sb, sc, sd;
        logic        sm;

        rst_n  = 1'b0;
        a_in   = 64'h1234_5678_9ABC_DEF0;
        b_in   = 64'hFFFF_0000_FFFF_0000;
        c_in   = 64'h1;
        d_in   = 64'h7;
        mode64 = 1'b1;
        #1;
        check("reset_immediate", sum_out, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", sum_out, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        drive(64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 1'b1);
        drive(64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 1'b0);
        drive(64'h0000_0001_0000_000A, 64'h0000_0002_0000_0FFF,
              64'h0000_0000_0000_0018, 64'h0000_0000_0000_01A1, 1'b0);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Streaming run with a mode flip at cycle 7.
        sa = '0; sb = '0; sc = '0; sd = '0;
        for (int i = 0; i < 15; i++) begin
            sa = (sa << 4) + 64'hA;
            sb = (sb << 12) + 64'hFFF;
            sc = (sc << 5) + 64'h18;
            sd = (sd << 9) + 64'h1A1;
            sm = (i < 7);
            drive(sa, sb, sc, sd, sm);
        end

        for (int i = 0; i < 200; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream: in-flight results are dropped and the output clears at once.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_midstream", sum_out, 64'h0);
        pend.delete();
        infl.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        repeat (LAT + 3) @(negedge clk);
        if (pend.size() != 0 || infl.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results still outstanding, expected 0",
                     pend.size() + infl.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound, expected completion");
        $fatal(1, "timeout");
    end

endmodule
